// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit producing HI/LO for MULT and DIV.
// Radix-2 Booth multiply and restoring divide, one iteration per clock, WIDTH iterations.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    DONE  = 3'd3,
    DZERO = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] acc;      // Booth accumulator, or partial remainder in the low bits
  logic [WIDTH-1:0] qReg;   // multiplier Q, or dividend/quotient shift register
  logic           qm1;
  logic [WIDTH:0] operand;  // sign-extended multiplicand, or zero-extended |divisor|
  logic           negQuo;
  logic           negRem;

  logic [WIDTH:0]   boothAcc;
  logic [WIDTH:0]   boothAccSh;
  logic [WIDTH-1:0] boothQSh;
  logic             boothQm1Sh;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] divRem;
  logic [WIDTH-1:0] divQuo;
  logic             divBit;
  logic [WIDTH-1:0] quoFinal;
  logic [WIDTH-1:0] remFinal;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  // Next-iteration values for both the Booth step and the restoring-divide step.
  always_comb begin
    boothAcc = acc;
    case ({qReg[0], qm1})
      2'b10:   boothAcc = acc - operand;
      2'b01:   boothAcc = acc + operand;
      default: boothAcc = acc;
    endcase
    {boothAccSh, boothQSh, boothQm1Sh} = {boothAcc[WIDTH], boothAcc, qReg};

    divShift = {acc[WIDTH-1:0], qReg[WIDTH-1]};
    divTrial = divShift - operand;
    if (!divTrial[WIDTH]) begin
      divRem = divTrial[WIDTH-1:0];
      divBit = 1'b1;
    end else begin
      divRem = divShift[WIDTH-1:0];
      divBit = 1'b0;
    end
    divQuo = {qReg[WIDTH-2:0], divBit};

    if (negQuo) begin
      quoFinal = negate(divQuo);
    end else begin
      quoFinal = divQuo;
    end
    if (negRem) begin
      remFinal = negate(divRem);
    end else begin
      remFinal = divRem;
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= {CW{1'b0}};
      acc      <= {(WIDTH+1){1'b0}};
      qReg     <= {WIDTH{1'b0}};
      qm1      <= 1'b0;
      operand  <= {(WIDTH+1){1'b0}};
      negQuo   <= 1'b0;
      negRem   <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          cnt      <= {CW{1'b0}};
          if (start_mult) begin
            operand <= {a[WIDTH-1], a};
            acc     <= {(WIDTH+1){1'b0}};
            qReg    <= b;
            qm1     <= 1'b0;
            busy    <= 1'b1;
            state   <= MULT;
          end else if (start_div) begin
            if (b == {WIDTH{1'b0}}) begin
              state <= DZERO;
            end else begin
              operand <= {1'b0, magnitude(b)};
              acc     <= {(WIDTH+1){1'b0}};
              qReg    <= magnitude(a);
              negQuo  <= a[WIDTH-1] ^ b[WIDTH-1];
              negRem  <= a[WIDTH-1];
              busy    <= 1'b1;
              state   <= DIV;
            end
          end else begin
            state <= IDLE;
          end
        end
        MULT: begin
          if (cnt == LAST) begin
            {hi, lo} <= {boothAccSh[WIDTH-1:0], boothQSh};
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            acc   <= boothAccSh;
            qReg  <= boothQSh;
            qm1   <= boothQm1Sh;
            cnt   <= cnt + CW'(1);
          end
        end
        DIV: begin
          if (cnt == LAST) begin
            lo    <= quoFinal;
            hi    <= remFinal;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc  <= {1'b0, divRem};
            qReg <= divQuo;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        DZERO: begin
          div_zero <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random operations
// checked against plain signed 64-bit arithmetic.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdlHi = 32'd0;
  logic [31:0] mdlLo = 32'd0;
  int          checks = 0;
  int          fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && (done || div_zero)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_completion: actual done=%b div_zero=%b required no pulse", done, div_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("div_zero_flag", {63'd0, div_zero}, {63'd0, e.dz});
        chk("done_flag", {63'd0, done}, {63'd0, !e.dz});
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
      end
    end
  end

  // One operation: push the expectation, issue the start, track busy and latency.
  task automatic run(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y,
                     input int pokeAt, input int abortAt);
    exp_t        e;
    longint      sx, sy, r;
    logic [63:0] p;
    int          n, busyCnt, expEnd;
    logic        fin, aborted;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (m) begin
      r = sx * sy; p = r;
      e.dz = 1'b0; e.hi = p[63:32]; e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.dz = 1'b1; e.hi = mdlHi; e.lo = mdlLo;
    end else begin
      r = sx / sy; p = r; e.lo = p[31:0];
      r = sx % sy; p = r; e.hi = p[31:0];
      e.dz = 1'b0;
    end
    if (!e.dz) begin
      mdlHi = e.hi;
      mdlLo = e.lo;
    end
    sb.push_back(e);
    expEnd = e.dz ? 1 : 32;

    @(negedge clock);
    start_mult = m; start_div = d; a = x; b = y;
    @(posedge clock); #1;
    start_mult = 1'b0; start_div = 1'b0; a = $urandom; b = $urandom;
    busyCnt = busy ? 1 : 0;
    n = 0; fin = 1'b0; aborted = 1'b0;
    while (!fin && n < 40) begin
      start_div = (n == pokeAt) ? 1'b1 : 1'b0;
      if (n == abortAt) begin
        reset = 1'b1;
        sb.delete();
        mdlHi = 32'd0;
        mdlLo = 32'd0;
      end
      @(posedge clock); #1;
      n++;
      if (reset) begin
        reset = 1'b0;
        aborted = 1'b1;
        fin = 1'b1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
      end else if (done || div_zero) begin
        fin = 1'b1;
      end else if (busy) begin
        busyCnt++;
      end else begin
        busyCnt = busyCnt;
      end
    end
    start_div = 1'b0;
    if (aborted) begin
      repeat (40) @(posedge clock);
    end else begin
      chk("latency", 64'(n), 64'(expEnd));
      chk("busy_cycles", 64'(busyCnt), e.dz ? 64'd0 : 64'd32);
      @(posedge clock);
      @(posedge clock);
    end
  endtask

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: pick = 32'h8000_0000;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h7FFF_FFFF;
      3: pick = 32'h0000_0001;
      4: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;

    run(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
    run(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
    run(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1);
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run(1'b1, 1'b0, 32'h1111_1111, 32'h0000_0002, -1, -1);
    run(1'b0, 1'b1, 32'd5, 32'd0, -1, -1);
    run(1'b1, 1'b1, 32'd6, 32'd3, 10, -1);
    run(1'b0, 1'b1, 32'd1000, 32'd7, -1, 15);
    run(1'b1, 1'b0, 32'd2, 32'd3, -1, -1);

    for (int i = 0; i < 30; i++) begin
      int kind;
      logic [31:0] x, y;
      kind = $urandom_range(0, 3);
      x = pick();
      y = pick();
      if (kind == 3) y = 32'($urandom_range(0, 2));
      run(kind < 2, kind >= 2, x, y, -1, -1);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
